// File: rtl/target_addr_pipeline_if.sv
// Bus between a branch-target producer and the delayed-redirect pipeline.
// The producer (master) drives targets and control; the pipeline (slave) reports redirects.
interface target_addr_pipeline_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  clk_enable;
    logic                  tgt_valid_in;
    logic [ADDR_WIDTH-1:0] tgt_addr_in;
    logic                  flush;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic [CNT_W-1:0]      pending_count;
    logic                  overflow;

    modport master (
        output clk_enable, tgt_valid_in, tgt_addr_in, flush,
        input  redirect_valid, redirect_addr, pending_count, overflow
    );

    modport slave (
        input  clk_enable, tgt_valid_in, tgt_addr_in, flush,
        output redirect_valid, redirect_addr, pending_count, overflow
    );
endinterface

// File: rtl/target_addr_pipeline.sv
// Holds taken-branch targets for DELAY enabled cycles (delay slots), then presents
// the oldest one as a fetch redirect. Entries are kept packed oldest-first at index 0.
module target_addr_pipeline #(
    parameter int ADDR_WIDTH = 32,
    parameter int DELAY      = 1,
    parameter int DEPTH      = 2
) (
    input logic                   clk,
    input logic                   reset,
    target_addr_pipeline_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  valid_q [DEPTH];
    logic                  valid_d [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
    logic [2:0]            cnt_q   [DEPTH];
    logic [2:0]            cnt_d   [DEPTH];
    logic [CNT_W-1:0]      pending_q;
    logic [CNT_W-1:0]      pending_d;
    logic                  overflow_q;
    logic                  overflow_d;

    logic                  head_ready;
    logic                  retire;
    logic                  push_ok;
    logic [CNT_W-1:0]      len_after;
    logic [CNT_W-1:0]      push_idx;
    logic                  sh_valid;
    logic [ADDR_WIDTH-1:0] sh_addr;
    logic [2:0]            sh_cnt;

    always_comb begin
        head_ready = valid_q[0] && (cnt_q[0] == 3'd0);
        retire     = bus.clk_enable && head_ready;
        // Occupancy once the head has left; a push is judged against this, so a
        // full queue still accepts a push on the same edge its head retires.
        len_after  = pending_q - CNT_W'(retire);
        push_ok    = bus.clk_enable && bus.tgt_valid_in &&
                     (bus.flush || (len_after < CNT_W'(DEPTH)));
        push_idx   = bus.flush ? '0 : len_after;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        sh_valid   = 1'b0;
        sh_addr    = '0;
        sh_cnt     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            addr_d[i]  = addr_q[i];
            cnt_d[i]   = cnt_q[i];
        end

        if (bus.clk_enable) begin
            pending_d = push_idx + CNT_W'(push_ok);
            if (bus.tgt_valid_in && !push_ok)
                overflow_d = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                sh_valid = 1'b0;
                sh_addr  = '0;
                sh_cnt   = '0;
                if (!bus.flush) begin
                    if (!retire) begin
                        sh_valid = valid_q[i];
                        sh_addr  = addr_q[i];
                        sh_cnt   = cnt_q[i];
                    end else if (i < DEPTH - 1) begin
                        sh_valid = valid_q[(i + 1 < DEPTH) ? i + 1 : i];
                        sh_addr  = addr_q[(i + 1 < DEPTH) ? i + 1 : i];
                        sh_cnt   = cnt_q[(i + 1 < DEPTH) ? i + 1 : i];
                    end
                end
                valid_d[i] = sh_valid;
                addr_d[i]  = sh_addr;
                cnt_d[i]   = (sh_valid && sh_cnt != 3'd0) ? sh_cnt - 3'd1 : sh_cnt;
                if (push_ok && int'(push_idx) == i) begin
                    valid_d[i] = 1'b1;
                    addr_d[i]  = bus.tgt_addr_in;
                    cnt_d[i]   = 3'(DELAY);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                addr_q[i]  <= addr_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.redirect_valid = head_ready;
    assign bus.redirect_addr  = head_ready ? addr_q[0] : '0;
    assign bus.pending_count  = pending_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_target_addr_pipeline.sv
// Directed table, hand sequences and a random queue-model comparison for two
// pipeline configurations (DELAY=1 and DELAY=2, both DEPTH=2) driven in parallel.
module tb_target_addr_pipeline;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    target_addr_pipeline_if #(.ADDR_WIDTH(32), .DEPTH(2)) if1 ();
    target_addr_pipeline_if #(.ADDR_WIDTH(32), .DEPTH(2)) if2 ();

    target_addr_pipeline #(.ADDR_WIDTH(32), .DELAY(1), .DEPTH(2)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (if1.slave)
    );
    target_addr_pipeline #(.ADDR_WIDTH(32), .DELAY(2), .DEPTH(2)) dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        en;
        logic        v;
        logic [31:0] addr;
        logic        fl;
        logic        rst;
        logic        exp_rv;
        logic [31:0] exp_ra;
        int          exp_pc;
        logic        exp_ov;
    } vec_t;

    vec_t tbl [24];

    // Reference model state: [0] for DELAY=1, [1] for DELAY=2.
    logic [31:0] m_addr [2][8];
    int          m_cnt  [2][8];
    int          m_len  [2];
    logic        m_ovf  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic [31:0] a,
                         input logic fl, input logic r);
        if1.clk_enable = en;  if1.tgt_valid_in = v;  if1.tgt_addr_in = a;  if1.flush = fl;
        if2.clk_enable = en;  if2.tgt_valid_in = v;  if2.tgt_addr_in = a;  if2.flush = fl;
        rst = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic rv, input logic [31:0] ra,
                          input int pc, input logic ov);
        check({tag, ".d1.redirect_valid"}, 32'(if1.redirect_valid), 32'(rv));
        check({tag, ".d1.redirect_addr"},  if1.redirect_addr,       ra);
        check({tag, ".d1.pending_count"},  32'(if1.pending_count),  32'(pc));
        check({tag, ".d1.overflow"},       32'(if1.overflow),       32'(ov));
    endtask

    task automatic check2(input string tag, input logic rv, input logic [31:0] ra,
                          input int pc, input logic ov);
        check({tag, ".d2.redirect_valid"}, 32'(if2.redirect_valid), 32'(rv));
        check({tag, ".d2.redirect_addr"},  if2.redirect_addr,       ra);
        check({tag, ".d2.pending_count"},  32'(if2.pending_count),  32'(pc));
        check({tag, ".d2.overflow"},       32'(if2.overflow),       32'(ov));
    endtask

    task automatic model_step(input int m, input int dly, input int dep,
                              input logic en, input logic v, input logic [31:0] a,
                              input logic fl, input logic r);
        logic rv;
        if (r) begin
            m_len[m] = 0;
            m_ovf[m] = 1'b0;
        end else if (en) begin
            rv = (m_len[m] > 0) && (m_cnt[m][0] == 0);
            if (fl) begin
                m_len[m] = 0;
            end else begin
                if (rv) begin
                    for (int k = 0; k < 7; k++) begin
                        m_addr[m][k] = m_addr[m][k+1];
                        m_cnt[m][k]  = m_cnt[m][k+1];
                    end
                    m_len[m]--;
                end
                for (int k = 0; k < m_len[m]; k++)
                    if (m_cnt[m][k] > 0) m_cnt[m][k]--;
            end
            if (v) begin
                if (m_len[m] < dep) begin
                    m_addr[m][m_len[m]] = a;
                    m_cnt[m][m_len[m]]  = dly;
                    m_len[m]++;
                end else begin
                    m_ovf[m] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic        m_rv;
        logic [31:0] m_ra;
        n_checks = 0;
        n_fail   = 0;

        //             en  v   addr          fl  rst  rv  ra            pc ov
        tbl[0]  = '{1'b1,1'b1,32'hBFC00100,1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[1]  = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b1,32'hBFC00100,  1,1'b0};
        tbl[2]  = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b0,32'h0,         0,1'b0};
        tbl[3]  = '{1'b1,1'b1,32'h11,      1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[4]  = '{1'b0,1'b1,32'h99,      1'b1,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[5]  = '{1'b0,1'b0,32'h0,       1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[6]  = '{1'b0,1'b1,32'h77,      1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[7]  = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b1,32'h11,        1,1'b0};
        tbl[8]  = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b0,32'h0,         0,1'b0};
        tbl[9]  = '{1'b1,1'b1,32'hA0,      1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[10] = '{1'b1,1'b1,32'hB0,      1'b0,1'b0, 1'b1,32'hA0,        2,1'b0};
        tbl[11] = '{1'b1,1'b1,32'hC0,      1'b0,1'b0, 1'b1,32'hB0,        2,1'b0};
        tbl[12] = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b1,32'hC0,        1,1'b0};
        tbl[13] = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b0,32'h0,         0,1'b0};
        tbl[14] = '{1'b1,1'b1,32'h400,     1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[15] = '{1'b1,1'b1,32'h800,     1'b1,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[16] = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b1,32'h800,       1,1'b0};
        tbl[17] = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b0,32'h0,         0,1'b0};
        tbl[18] = '{1'b1,1'b1,32'h1,       1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[19] = '{1'b1,1'b1,32'h2,       1'b0,1'b0, 1'b1,32'h1,         2,1'b0};
        tbl[20] = '{1'b1,1'b1,32'h5,       1'b0,1'b1, 1'b0,32'h0,         0,1'b0};
        tbl[21] = '{1'b1,1'b1,32'h6,       1'b0,1'b0, 1'b0,32'h0,         1,1'b0};
        tbl[22] = '{1'b0,1'b1,32'h7,       1'b1,1'b1, 1'b0,32'h0,         0,1'b0};
        tbl[23] = '{1'b1,1'b0,32'h0,       1'b0,1'b0, 1'b0,32'h0,         0,1'b0};

        // Reset state
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        check1("reset", 1'b0, 32'h0, 0, 1'b0);
        check2("reset", 1'b0, 32'h0, 0, 1'b0);
        $display("reset: d1 rv=%0b pc=%0d ov=%0b", if1.redirect_valid, if1.pending_count, if1.overflow);

        // Directed table against the DELAY=1 instance
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].addr, tbl[i].fl, tbl[i].rst);
            tick();
            check1($sformatf("vec%0d", i), tbl[i].exp_rv, tbl[i].exp_ra, tbl[i].exp_pc, tbl[i].exp_ov);
            $display("vec%0d: en=%0b v=%0b addr=0x%08h fl=%0b rst=%0b -> rv=%0b ra=0x%08h pc=%0d ov=%0b",
                     i, tbl[i].en, tbl[i].v, tbl[i].addr, tbl[i].fl, tbl[i].rst,
                     if1.redirect_valid, if1.redirect_addr, if1.pending_count, if1.overflow);
        end

        // DELAY=2 sequence: overflow on third push, sticky through flush, cleared by reset
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0); tick(); check2("ovf_e1", 1'b0, 32'h0,   1, 1'b0);
        $display("ovf_e1: d2 rv=%0b pc=%0d ov=%0b", if2.redirect_valid, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0); tick(); check2("ovf_e2", 1'b0, 32'h0,   2, 1'b0);
        $display("ovf_e2: d2 rv=%0b pc=%0d ov=%0b", if2.redirect_valid, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0); tick(); check2("ovf_e3", 1'b1, 32'h100, 2, 1'b1);
        $display("ovf_e3: d2 rv=%0b ra=0x%08h pc=%0d ov=%0b", if2.redirect_valid, if2.redirect_addr, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b0, 32'h0,   1'b0, 1'b0); tick(); check2("ovf_e4", 1'b1, 32'h200, 1, 1'b1);
        $display("ovf_e4: d2 rv=%0b ra=0x%08h pc=%0d ov=%0b", if2.redirect_valid, if2.redirect_addr, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b0, 32'h0,   1'b0, 1'b0); tick(); check2("ovf_e5", 1'b0, 32'h0,   0, 1'b1);
        $display("ovf_e5: d2 rv=%0b pc=%0d ov=%0b", if2.redirect_valid, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b1, 32'h800, 1'b1, 1'b0); tick(); check2("ovf_e6", 1'b0, 32'h0,   1, 1'b1);
        $display("ovf_e6: d2 rv=%0b pc=%0d ov=%0b", if2.redirect_valid, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b0, 32'h0,   1'b0, 1'b0); tick(); check2("ovf_e7", 1'b0, 32'h0,   1, 1'b1);
        $display("ovf_e7: d2 rv=%0b pc=%0d ov=%0b", if2.redirect_valid, if2.pending_count, if2.overflow);
        drive(1'b1, 1'b0, 32'h0,   1'b0, 1'b0); tick(); check2("ovf_e8", 1'b1, 32'h800, 1, 1'b1);
        $display("ovf_e8: d2 rv=%0b ra=0x%08h pc=%0d ov=%0b", if2.redirect_valid, if2.redirect_addr, if2.pending_count, if2.overflow);
        drive(1'b0, 1'b1, 32'h900, 1'b0, 1'b1); tick(); check2("ovf_rst", 1'b0, 32'h0,  0, 1'b0);
        $display("ovf_rst: d2 rv=%0b pc=%0d ov=%0b", if2.redirect_valid, if2.pending_count, if2.overflow);

        // Random comparison against the queue model
        for (int m = 0; m < 2; m++) begin
            m_len[m] = 0;
            m_ovf[m] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                m_addr[m][k] = '0;
                m_cnt[m][k]  = 0;
            end
        end
        for (int c = 0; c < 2000; c++) begin
            logic        r_en, r_v, r_fl, r_rst;
            logic [31:0] r_a;
            r_en  = ($urandom_range(0, 9) < 8);
            r_v   = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            r_fl  = ($urandom_range(0, 19) == 0);
            r_rst = ($urandom_range(0, 49) == 0);
            drive(r_en, r_v, r_a, r_fl, r_rst);
            model_step(0, 1, 2, r_en, r_v, r_a, r_fl, r_rst);
            model_step(1, 2, 2, r_en, r_v, r_a, r_fl, r_rst);
            tick();
            for (int m = 0; m < 2; m++) begin
                m_rv = (m_len[m] > 0) && (m_cnt[m][0] == 0);
                m_ra = m_rv ? m_addr[m][0] : 32'h0;
                if (m == 0) check1($sformatf("rnd%0d", c), m_rv, m_ra, m_len[m], m_ovf[m]);
                else        check2($sformatf("rnd%0d", c), m_rv, m_ra, m_len[m], m_ovf[m]);
            end
        end
        $display("random: 2000 cycles compared on both instances");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/target_addr_pipeline.md
TARGET_ADDR_PIPELINE -- requirements
Module: target_addr_pipeline

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of every target address.
REQ-002 Parameter DELAY, default 1, legal 1..7: enabled cycles between target capture and redirect (delay slots).
REQ-003 Parameter DEPTH, default 2, legal 1..8: number of pending target entries held.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clk_enable  input  1  pipeline advance; 0 freezes all state.
REQ-007 tgt_valid_in  input  1  taken branch/jump presents a target this cycle.
REQ-008 tgt_addr_in  input  ADDR_WIDTH  target address qualified by tgt_valid_in.
REQ-009 flush  input  1  discard all pending entries.
REQ-010 redirect_valid  output  1  head entry's delay has expired; fetch must use redirect_addr.
REQ-011 redirect_addr  output  ADDR_WIDTH  head entry address; 0 when redirect_valid=0.
REQ-012 pending_count  output  $clog2(DEPTH+1)  number of live entries.
REQ-013 overflow  output  1  sticky: a target was dropped because the queue was full.

Function
REQ-014 Each entry SHALL hold {valid, addr, count[2:0]}; entries SHALL be ordered oldest-first (head = oldest).
REQ-015 All outputs SHALL be driven from registered state only; no combinational input-to-output path.
REQ-016 When clk_enable=0 at an edge, no state SHALL change and tgt_valid_in/flush SHALL be ignored.
REQ-017 At an enabled edge, every live entry with count>0 SHALL decrement count by 1.
REQ-018 At an enabled edge with tgt_valid_in=1, a new entry {1, tgt_addr_in, DELAY} SHALL be appended at the tail.
REQ-019 redirect_valid SHALL be 1 exactly when the head entry is valid with count=0; redirect_addr SHALL then equal its addr.
REQ-020 At an enabled edge where redirect_valid=1, the head entry SHALL retire and the remaining entries SHALL shift one place toward head.
REQ-021 Latency: target captured at enabled edge k SHALL produce redirect_valid=1 in the cycle after the (k+DELAY)th enabled edge, for exactly one enabled cycle; stalled cycles extend it.
REQ-022 Only the head can reach count=0, because entries are created in order and decrement in lockstep; at most one retire per edge.
REQ-023 Full = pending_count==DEPTH; a push when full with no simultaneous retire SHALL be dropped and SHALL set overflow=1.
REQ-024 A push and a retire at the same enabled edge when full SHALL both occur; pending_count unchanged; overflow unchanged.
REQ-025 Enabled flush=1 SHALL invalidate all existing entries, including a head at count=0; a simultaneous tgt_valid_in=1 SHALL still be appended, leaving pending_count=1.
REQ-026 overflow SHALL be cleared only by reset; flush does not clear it.
REQ-027 pending_count SHALL equal entries after the edge: old - retire + accepted push (flush: 0 + push).

Reset
REQ-028 reset=1 at an edge SHALL clear all entries regardless of clk_enable, flush or tgt_valid_in; any push that edge is discarded.
REQ-029 After reset: redirect_valid=0, redirect_addr=0, pending_count=0, overflow=0.
REQ-030 Reset asserted mid-countdown SHALL suppress the pending redirect entirely.

Verification
REQ-031 DELAY=1: push 0xBFC00100 at edge 1, enable held -> redirect_valid=1, redirect_addr=0xBFC00100 after edge 2 only; pending_count 1,1,0 after edges 1..3.
REQ-032 DELAY=1: push at edge 1, clk_enable=0 for edges 2-4 -> outputs frozen (count=1, redirect_valid=0); redirect after edge 5.
REQ-033 DELAY=2, DEPTH=2: pushes 0x100,0x200,0x300 at edges 1,2,3 -> 0x300 dropped, overflow=1; redirects 0x100 after edge 3, 0x200 after edge 4.
REQ-034 DELAY=1, DEPTH=2: push 0xA0 edge 1, push 0xB0 edge 2 with head retiring at edge 3 plus push 0xC0 -> all accepted, overflow=0, redirects 0xA0, 0xB0, 0xC0 in consecutive cycles.
REQ-035 Push 0x400 edge 1, flush+push 0x800 edge 2 -> 0x400 never redirected; 0x800 redirected DELAY enabled edges later; overflow unchanged.
REQ-036 Random: 2000 cycles of random clk_enable/tgt_valid_in/flush/reset compared against a cycle-accurate queue model; any mismatch is an error; bench has a timeout.
